// File: rtl/mod_pkg.sv
// Shared types for the modular-arithmetic streaming blocks: word, widened
// difference, and the pipeline stage record.
package mod_pkg;

  localparam int MOD_BITWIDTH = 32;

  typedef logic [MOD_BITWIDTH-1:0] mod_word_t;
  typedef logic [MOD_BITWIDTH:0]   mod_diff_t;

  typedef struct packed {
    logic      valid;
    mod_diff_t diff;
    mod_word_t q;
    logic      err;
  } mod_stage_t;

  // The extra MSB of the result is the borrow out of the subtraction.
  function automatic mod_diff_t mod_raw_diff(input mod_word_t a, input mod_word_t b);
    return {1'b0, a} - {1'b0, b};
  endfunction

endpackage

// File: rtl/mod_sub_correct.sv
// Conditional add-Q correction: maps a borrowed raw difference back into [0, Q).
module mod_sub_correct
  import mod_pkg::*;
(
  input  mod_diff_t i_diff,
  input  mod_word_t i_q,
  output mod_word_t o_res
);

  // The add may carry out of the word; dropping it is exactly the mod-2^N wrap we need.
  assign o_res = i_diff[MOD_BITWIDTH] ? (i_diff[MOD_BITWIDTH-1:0] + i_q)
                                      : i_diff[MOD_BITWIDTH-1:0];

endmodule

// File: rtl/mod_differentiator.sv
// Streaming modular differencer, 2-stage pipeline with valid/ready on both sides.
// Optional input range check (oErr port) enabled by MOD_DIFF_RANGE_CHECK_EN.
module mod_differentiator
  import mod_pkg::*;
#(
  parameter int BITWIDTH = MOD_BITWIDTH
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iValid,
  output logic                oReady,
  input  logic                iClr,
  input  logic [BITWIDTH-1:0] iData,
  input  logic [BITWIDTH-1:0] iQ,
  output logic                oValid,
  input  logic                iReady,
  output logic [BITWIDTH-1:0] oData
`ifdef MOD_DIFF_RANGE_CHECK_EN
  ,
  output logic                oErr
`endif
);

  logic       w_adv;
  logic       w_accept;
  logic       w_bad;
  mod_word_t  w_base;
  mod_word_t  w_corr;
  mod_word_t  w_res;

  mod_word_t  r_prev;
  mod_stage_t r_s1;
  logic       r_s2_valid;
  mod_word_t  r_data;

  assign w_adv    = iReady || !r_s2_valid;
  assign w_accept = iValid && w_adv;
  assign w_base   = iClr ? '0 : r_prev;

`ifdef MOD_DIFF_RANGE_CHECK_EN
  assign w_bad = (iData >= iQ);
`else
  assign w_bad = 1'b0;
`endif

  // A rejected sample leaves history alone, but a clear on it still takes effect.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_prev <= '0;
    end else if (w_accept) begin
      if (!w_bad) begin
        r_prev <= iData;
      end else if (iClr) begin
        r_prev <= '0;
      end
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_s1 <= '0;
    end else if (w_adv) begin
      r_s1.valid <= w_accept;
      if (w_accept) begin
        r_s1.diff <= w_bad ? '0 : mod_raw_diff(iData, w_base);
        r_s1.q    <= iQ;
        r_s1.err  <= w_bad;
      end
    end
  end

  mod_sub_correct u_correct (
    .i_diff (r_s1.diff),
    .i_q    (r_s1.q),
    .o_res  (w_corr)
  );

  assign w_res = r_s1.err ? '0 : w_corr;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_s2_valid <= 1'b0;
      r_data     <= '0;
    end else if (w_adv) begin
      r_s2_valid <= r_s1.valid;
      if (r_s1.valid) begin
        r_data <= w_res;
      end
    end
  end

`ifdef MOD_DIFF_RANGE_CHECK_EN
  logic r_err;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_err <= 1'b0;
    end else if (w_adv && r_s1.valid) begin
      r_err <= r_s1.err;
    end
  end

  assign oErr = r_err;
`endif

  assign oReady = w_adv;
  assign oValid = r_s2_valid;
  assign oData  = r_data;

endmodule

// File: tb/tb_mod_differentiator.sv
// Directed bench for mod_differentiator with a queue scoreboard of expected results.
// Build with MOD_DIFF_RANGE_CHECK_EN defined to also exercise the oErr path.
module tb_mod_differentiator;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iValid;
  logic        oReady;
  logic        iClr;
  logic [31:0] iData;
  logic [31:0] iQ;
  logic        oValid;
  logic        iReady;
  logic [31:0] oData;
`ifdef MOD_DIFF_RANGE_CHECK_EN
  logic        oErr;
`endif

  always #5 iClk = ~iClk;

  mod_differentiator dut (
    .iClk   (iClk),
    .iRst   (iRst),
    .iValid (iValid),
    .oReady (oReady),
    .iClr   (iClr),
    .iData  (iData),
    .iQ     (iQ),
    .oValid (oValid),
    .iReady (iReady),
    .oData  (oData)
`ifdef MOD_DIFF_RANGE_CHECK_EN
    ,
    .oErr   (oErr)
`endif
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          acc_cyc;
    int          acc_stall;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc_n  = 0;
  int          stalls = 0;
  logic [31:0] m_prev = '0;
  logic        held_v = 1'b0;
  logic [31:0] held_d = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive, check outputs, update the model, advance to the next negedge.
  task automatic step(input logic v, input logic clr, input logic [31:0] d,
                      input logic [31:0] q, input logic rdy);
    exp_t        e;
    logic [31:0] base;
    logic [63:0] wide;
    iValid = v;
    iClr   = clr;
    iData  = d;
    iQ     = q;
    iReady = rdy;
    #1;
    if (held_v) begin
      chk("hold_valid", {63'd0, oValid}, 64'd1);
      chk("hold_data", {32'd0, oData}, {32'd0, held_d});
    end
    if (oValid && iReady) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", {63'd0, oValid}, 64'd0);
      end else begin
        e = sb.pop_front();
        $display("OUT cycle=%0d data=%0h expected=%0h", cyc_n, oData, e.data);
        chk("data", {32'd0, oData}, {32'd0, e.data});
`ifdef MOD_DIFF_RANGE_CHECK_EN
        chk("err", {63'd0, oErr}, {63'd0, e.err});
`endif
        chk("latency", 64'(cyc_n - e.acc_cyc), 64'(2 + stalls - e.acc_stall));
      end
    end
    if (v && oReady) begin
      base = clr ? 32'd0 : m_prev;
      e.err = 1'b0;
`ifdef MOD_DIFF_RANGE_CHECK_EN
      if (d >= q) begin
        e.err  = 1'b1;
        e.data = '0;
        if (clr) m_prev = '0;
      end else
`endif
      begin
        wide   = (d >= base) ? (64'(d) - 64'(base)) : (64'(d) + 64'(q) - 64'(base));
        e.data = wide[31:0];
        m_prev = d;
      end
      e.acc_cyc   = cyc_n;
      e.acc_stall = stalls;
      sb.push_back(e);
    end
    if (!oReady) stalls++;
    held_v = oValid && !iReady;
    held_d = oData;
    @(posedge iClk);
    @(negedge iClk);
    cyc_n++;
  endtask

  initial begin
    logic [31:0] bp_val;
    iRst   = 1'b1;
    iValid = 1'b0;
    iClr   = 1'b0;
    iData  = '0;
    iQ     = 32'd13;
    iReady = 1'b1;
    @(negedge iClk);
    chk("rst_valid", {63'd0, oValid}, 64'd0);
    chk("rst_ready", {63'd0, oReady}, 64'd1);
    chk("rst_data", {32'd0, oData}, 64'd0);
`ifdef MOD_DIFF_RANGE_CHECK_EN
    chk("rst_err", {63'd0, oErr}, 64'd0);
`endif
    iRst = 1'b0;

    // Accumulator of 10 mod 13
    step(1'b1, 1'b0, 32'd10, 32'd13, 1'b1);
    step(1'b1, 1'b0, 32'd7,  32'd13, 1'b1);
    step(1'b1, 1'b0, 32'd4,  32'd13, 1'b1);
    step(1'b1, 1'b0, 32'd1,  32'd13, 1'b1);
    step(1'b1, 1'b0, 32'd11, 32'd13, 1'b1);

    // Clear with accept, then continue from the cleared history
    step(1'b1, 1'b1, 32'd5, 32'd13, 1'b1);
    step(1'b1, 1'b0, 32'd8, 32'd13, 1'b1);

    // Wrap cases, small and near-full-width modulus
    step(1'b1, 1'b0, 32'd12, 32'd13, 1'b1);
    step(1'b1, 1'b0, 32'd0,  32'd13, 1'b1);
    step(1'b1, 1'b0, 32'hFFFF_FFFA, 32'hFFFF_FFFB, 1'b1);
    step(1'b1, 1'b0, 32'd0,         32'hFFFF_FFFB, 1'b1);

    // iClr during a bubble is ignored
    step(1'b0, 1'b1, 32'd0, 32'd100, 1'b1);

    // Backpressure: iReady low for 4 cycles mid-stream
    for (int i = 0; i < 10; i++) begin
      bp_val = 32'((i * 37 + 11) % 100);
      step(1'b1, 1'b0, bp_val, 32'd100, !(i >= 2 && i < 6));
      if (i == 3) begin
        #1;
        chk("bp_oready", {63'd0, oReady}, 64'd0);
      end
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, 32'd13, 1'b1);
    chk("drain_bp", 64'(sb.size()), 64'd0);

    // Asynchronous reset mid-stream
    step(1'b1, 1'b0, 32'd5, 32'd13, 1'b1);
    step(1'b1, 1'b0, 32'd9, 32'd13, 1'b1);
    #2;
    iRst = 1'b1;
    #1;
    chk("arst_valid", {63'd0, oValid}, 64'd0);
    chk("arst_ready", {63'd0, oReady}, 64'd1);
    chk("arst_data", {32'd0, oData}, 64'd0);
    sb.delete();
    m_prev = '0;
    held_v = 1'b0;
    @(negedge iClk);
    iRst = 1'b0;
    step(1'b1, 1'b0, 32'd4, 32'd13, 1'b1);

`ifdef MOD_DIFF_RANGE_CHECK_EN
    // Out-of-range sample is flagged and does not disturb history
    step(1'b1, 1'b1, 32'd3,  32'd13, 1'b1);
    step(1'b1, 1'b0, 32'd20, 32'd13, 1'b1);
    step(1'b1, 1'b0, 32'd6,  32'd13, 1'b1);
`endif

    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0, 32'd13, 1'b1);
    chk("drain_final", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
